// File: rtl/eth_pkt_sfifo_if.sv
// Packet FIFO bus: write side (producer) and read side (consumer) in one bundle.
// master: drives wr_data/wr_en/wr_last/wr_drop/rd_en, observes status and read data.
// slave : the FIFO itself.
interface eth_pkt_sfifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_last;
  logic                  wr_drop;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_water_level;
  logic                  pkt_drop;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_water_level;
  logic [ADDR_WIDTH:0]   pkt_cnt;

  modport master (
    output wr_data, wr_en, wr_last, wr_drop, rd_en,
    input  full, almost_full, wr_water_level, pkt_drop,
    input  rd_data, rd_last, rd_valid, empty, almost_empty, rd_water_level, pkt_cnt
  );

  modport slave (
    input  wr_data, wr_en, wr_last, wr_drop, rd_en,
    output full, almost_full, wr_water_level, pkt_drop,
    output rd_data, rd_last, rd_valid, empty, almost_empty, rd_water_level, pkt_cnt
  );
endinterface

// File: rtl/eth_pkt_sfifo.sv
// Single-clock packet store-and-forward FIFO. Words become readable only once
// the last word of their packet is written; a packet can be dropped while being
// written (wr_drop) or is dropped automatically when it overflows the storage.
// Ports: clk, rst_n (synchronous, active-low), bus (eth_pkt_sfifo_if.slave).
module eth_pkt_sfifo #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned ALMOST_FULL_NUM  = 1000,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  eth_pkt_sfifo_if.slave bus
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned WORD_W = DATA_WIDTH + 1;

  typedef enum logic {ACCEPT = 1'b0, DISCARD = 1'b1} wr_state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  wr_state_t         state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]  cmt_ptr, cmt_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_level, rd_level;
  logic              full_c, empty_c;
  logic              mem_we, commit, drop_nxt, pkt_drop_q;
  logic              rd_fire;
  logic [WORD_W-1:0] rd_word;
  logic              rd_valid_q, rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [PTR_W-1:0]  pkt_cnt_q;

  // Occupancy from registered pointers only; uncommitted words count on the write side.
  assign wr_level = wr_ptr - rd_ptr;
  assign rd_level = cmt_ptr - rd_ptr;
  assign full_c   = (wr_level == PTR_W'(DEPTH));
  assign empty_c  = (cmt_ptr == rd_ptr);
  assign rd_fire  = bus.rd_en && !empty_c;
  assign rd_word  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Write FSM: ACCEPT stores words, DISCARD swallows the rest of an overflowed packet.
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cmt_ptr_nxt = cmt_ptr;
    mem_we      = 1'b0;
    commit      = 1'b0;
    drop_nxt    = 1'b0;
    if (bus.wr_drop) begin
      wr_ptr_nxt = cmt_ptr;
      drop_nxt   = 1'b1;
      state_nxt  = ACCEPT;
    end else begin
      case (state)
        ACCEPT: begin
          if (bus.wr_en) begin
            if (!full_c) begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + PTR_W'(1);
              if (bus.wr_last) begin
                cmt_ptr_nxt = wr_ptr + PTR_W'(1);
                commit      = 1'b1;
              end
            end else if (bus.wr_last) begin
              wr_ptr_nxt = cmt_ptr;
              drop_nxt   = 1'b1;
            end else begin
              state_nxt = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (bus.wr_en && bus.wr_last) begin
            wr_ptr_nxt = cmt_ptr;
            drop_nxt   = 1'b1;
            state_nxt  = ACCEPT;
          end
        end
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  // Write-side state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      pkt_drop_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      cmt_ptr    <= cmt_ptr_nxt;
      pkt_drop_q <= drop_nxt;
    end
  end

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.wr_data};
  end

  // Read side; read data holds while rd_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        rd_data_q <= rd_word[DATA_WIDTH-1:0];
        rd_last_q <= rd_word[DATA_WIDTH];
      end
      // Commit and end-of-packet read in the same cycle cancel out.
      case ({commit, rd_fire && rd_word[DATA_WIDTH]})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + PTR_W'(1);
        2'b01:   pkt_cnt_q <= pkt_cnt_q - PTR_W'(1);
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

  assign bus.full           = full_c;
  assign bus.empty          = empty_c;
  assign bus.wr_water_level = wr_level;
  assign bus.rd_water_level = rd_level;
  assign bus.almost_full    = (32'(wr_level) >= ALMOST_FULL_NUM);
  assign bus.almost_empty   = (32'(rd_level) <= ALMOST_EMPTY_NUM);
  assign bus.pkt_drop       = pkt_drop_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_last        = rd_last_q;
  assign bus.pkt_cnt        = pkt_cnt_q;
endmodule

// File: tb/tb_eth_pkt_sfifo.sv
// Randomized bench for eth_pkt_sfifo against a queue-based packet model.
module tb_eth_pkt_sfifo;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned AF    = 12;
  localparam int unsigned AE    = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  eth_pkt_sfifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  eth_pkt_sfifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: committed words, words of the packet being written, overflow flag.
  logic [DW:0]   cq[$];
  logic [DW:0]   pq[$];
  bit            disc;
  bit            e_valid, e_last, e_drop;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lasts_in_cq();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input bit rn, input bit we, input bit wl, input bit wd, input bit re);
    logic [DW:0] w;
    bit m_full, m_empty;
    int lvl;
    rst_n        = rn;
    bus.wr_en    = we;
    bus.wr_last  = wl;
    bus.wr_drop  = wd;
    bus.rd_en    = re;
    bus.wr_data  = DW'($urandom);
    @(posedge clk);
    if (!rn) begin
      cq.delete(); pq.delete(); disc = 0;
      e_valid = 0; e_last = 0; e_data = '0; e_drop = 0;
    end else begin
      m_full  = (cq.size() + pq.size()) == DEPTH;
      m_empty = cq.size() == 0;
      e_drop  = 0;
      e_valid = 0;
      if (re && !m_empty) begin
        w = cq.pop_front();
        e_valid = 1; e_last = w[DW]; e_data = w[DW-1:0];
      end
      if (wd) begin
        pq.delete(); e_drop = 1; disc = 0;
      end else if (disc) begin
        if (we && wl) begin pq.delete(); e_drop = 1; disc = 0; end
      end else if (we) begin
        if (!m_full) begin
          pq.push_back({wl, bus.wr_data});
          if (wl) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
          end
        end else if (wl) begin
          pq.delete(); e_drop = 1;
        end else begin
          disc = 1;
        end
      end
    end
    #1;
    lvl = cq.size() + pq.size();
    chk("rd_valid",     64'(bus.rd_valid),       64'(e_valid));
    chk("rd_data",      64'(bus.rd_data),        64'(e_data));
    chk("rd_last",      64'(bus.rd_last),        64'(e_last));
    chk("pkt_drop",     64'(bus.pkt_drop),       64'(e_drop));
    chk("full",         64'(bus.full),           64'(lvl == DEPTH));
    chk("empty",        64'(bus.empty),          64'(cq.size() == 0));
    chk("wr_level",     64'(bus.wr_water_level), 64'(lvl));
    chk("rd_level",     64'(bus.rd_water_level), 64'(cq.size()));
    chk("almost_full",  64'(bus.almost_full),    64'(lvl >= AF));
    chk("almost_empty", 64'(bus.almost_empty),   64'(cq.size() <= AE));
    chk("pkt_cnt",      64'(bus.pkt_cnt),        64'(lasts_in_cq()));
  endtask

  initial begin
    int rd_pct, last_div;
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_last = 0; bus.wr_drop = 0; bus.rd_en = 0; bus.wr_data = '0;
    disc = 0; e_valid = 0; e_last = 0; e_drop = 0; e_data = '0;

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // 3-word packet then read it out with rd_en held
    for (int i = 0; i < 3; i++) step(1, 1, i == 2, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);

    // Two words then explicit drop
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);

    // 20-word packet overflows 16-word storage and is discarded
    for (int i = 0; i < 20; i++) step(1, 1, i == 19, 0, 0);
    step(1, 0, 0, 0, 0);

    // Fill with 16 committed words, then simultaneous read and write at full
    for (int i = 0; i < 16; i++) step(1, 1, (i % 4) == 3, 0, 0);
    step(1, 1, 1, 0, 1);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 1);

    // Randomized traffic, varying read pressure and packet length
    for (int blk = 0; blk < 8; blk++) begin
      rd_pct   = $urandom_range(20, 95);
      last_div = (blk % 3 == 2) ? 22 : 5;
      for (int i = 0; i < 400; i++)
        step(1, $urandom_range(0, 99) < 65, $urandom_range(0, last_div - 1) == 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, 99) < rd_pct);
    end
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1);

    // Reset in the middle of a packet, with committed data behind it
    for (int i = 0; i < 3; i++) step(1, 1, i == 2, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_pkt_sfifo.md
ETH_PKT_SFIFO -- requirements
Module: eth_pkt_sfifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, log2 of storage depth in words (4..12).
REQ-003 SHALL have parameter ALMOST_FULL_NUM, default 1000, wr_water_level threshold for almost_full.
REQ-004 SHALL have parameter ALMOST_EMPTY_NUM, default 4, rd_water_level threshold for almost_empty.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port wr_data  in  DATA_WIDTH  write word.
REQ-008 SHALL have port wr_en  in  1  write strobe.
REQ-009 SHALL have port wr_last  in  1  marks the written word as the last word of its packet.
REQ-010 SHALL have port wr_drop  in  1  discard the packet currently being written.
REQ-011 SHALL have port full  out  1  no free word.
REQ-012 SHALL have port almost_full  out  1  write-side threshold flag.
REQ-013 SHALL have port wr_water_level  out  ADDR_WIDTH+1  words held, committed plus uncommitted.
REQ-014 SHALL have port pkt_drop  out  1  one-cycle pulse per discarded packet.
REQ-015 SHALL have port rd_en  in  1  read strobe.
REQ-016 SHALL have port rd_data  out  DATA_WIDTH  read word.
REQ-017 SHALL have port rd_last  out  1  last-word marker stored with rd_data.
REQ-018 SHALL have port rd_valid  out  1  rd_data/rd_last valid this cycle.
REQ-019 SHALL have port empty  out  1  no committed word readable.
REQ-020 SHALL have port almost_empty  out  1  read-side threshold flag.
REQ-021 SHALL have port rd_water_level  out  ADDR_WIDTH+1  committed unread words.
REQ-022 SHALL have port pkt_cnt  out  ADDR_WIDTH+1  committed packets whose last word is not yet read.

Function
REQ-023 SHALL store {wr_last, wr_data} per word in 2^ADDR_WIDTH x (DATA_WIDTH+1) memory; pointers wr_ptr, cmt_ptr, rd_ptr are ADDR_WIDTH+1 bits, wrap modulo 2^(ADDR_WIDTH+1).
REQ-024 SHALL compute full = (wr_ptr - rd_ptr == 2^ADDR_WIDTH) and empty = (cmt_ptr == rd_ptr) from registered pointers; a read in the same cycle does not unblock a write at full.
REQ-025 SHALL output wr_water_level = wr_ptr - rd_ptr and rd_water_level = cmt_ptr - rd_ptr; almost_full = (wr_water_level >= ALMOST_FULL_NUM); almost_empty = (rd_water_level <= ALMOST_EMPTY_NUM).
REQ-026 SHALL run write FSM with states ACCEPT and DISCARD.
REQ-027 In ACCEPT, wr_en & !full & !wr_drop SHALL write the word at wr_ptr and increment wr_ptr; if wr_last also set, cmt_ptr SHALL become wr_ptr+1 in the same clock edge.
REQ-028 wr_drop (any state) SHALL set wr_ptr := cmt_ptr, ignore any concurrent wr_en word, pulse pkt_drop next cycle, enter ACCEPT.
REQ-029 In ACCEPT, wr_en & full & !wr_drop SHALL set wr_ptr := cmt_ptr and pulse pkt_drop if wr_last, else enter DISCARD.
REQ-030 In DISCARD, wr_en words SHALL be ignored; wr_en & wr_last SHALL set wr_ptr := cmt_ptr, pulse pkt_drop, return to ACCEPT.
REQ-031 rd_en & !empty SHALL read mem[rd_ptr], increment rd_ptr; rd_data, rd_last, rd_valid SHALL appear one cycle later; rd_en while empty SHALL be ignored with rd_valid=0 next cycle.
REQ-032 rd_data/rd_last SHALL hold their value when rd_valid=0.
REQ-033 pkt_cnt SHALL +1 on commit, -1 on accepted read of a word with stored last bit, unchanged when both occur in one cycle.
REQ-034 A packet longer than 2^ADDR_WIDTH words SHALL always be discarded via REQ-029/030.
REQ-035 Only committed words SHALL ever be readable; uncommitted words SHALL never affect empty, rd_water_level or pkt_cnt.

Reset
REQ-036 With rst_n=0 at a clk edge, all pointers, pkt_cnt, pkt_drop, rd_valid, rd_data, rd_last SHALL be 0, FSM ACCEPT, so empty=1, full=0, almost_empty=1, almost_full=0.
REQ-037 Reset mid-packet or mid-discard SHALL abandon all contents without pkt_drop pulse; memory contents need not be cleared.

Verification
REQ-038 Write 3-word packet (last on word 3), read with rd_en held -> empty falls one cycle after last write; pkt_cnt 0->1->0; rd_last=1 only on third rd_valid.
REQ-039 Write 2 words, assert wr_drop -> wr_water_level 2->0, empty stays 1, pkt_drop pulses once.
REQ-040 ADDR_WIDTH=4: write 20-word packet -> full at 16 words, DISCARD, pkt_drop on word 20, wr_water_level 0, empty 1.
REQ-041 ADDR_WIDTH=4: fill 16 committed words, simultaneous rd_en and wr_en -> write rejected, water levels become 15.
REQ-042 Continuous writes/reads through 3 pointer wraps with random drops -> read stream equals committed packets in order.
REQ-043 rst_n low mid-packet -> all outputs at REQ-036 values next cycle, no pkt_drop.
